// File: rtl/simf_pass_seq.sv
// simf_pass_seq
//
// Multi-pass SIMF execution sequencer. Takes one vector instruction from
// issue, reads two 64-thread VGPR operands, processes them LANES threads per
// cycle through a LAT-deep lane pipeline and writes the 64-thread result
// back as a single masked VGPR write with done/retire reporting.
//
// Parameters
//   LANES : threads per pass (8, 16, 32, 64); PASSES = 64/LANES
//   LAT   : lane pipeline depth in register stages (1..8)
//
// Build option
//   SIMF_SEQ_DENORM_FLUSH_EN : when defined, MIN/MAX/NEG/ABS flush denormal
//   operands to a zero of the same sign before operating. MOV and the
//   bitwise ops never flush.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   issue_*                      instruction offer and its fields
//   exec_rd_exec_value           exec mask, captured at accept
//   vgpr_source{1,2}_data        operand data, thread t at [32t+31:32t]
//   issue_alu_ready              high only while idle
//   vgpr_source{1,2}_rd_en/addr  operand read strobes and addresses
//   vgpr_wr_en, vgpr_dest_*      result writeback, mask = captured exec
//   vgpr_instr_done(_wfid)       one-cycle completion pulse and its wfid
//   tracemon_retire_pc           PC of the completing instruction
//   state_dbg                    current sequencer state
//
// Handshake: an instruction is taken on a rising clock edge where both
// issue_alu_select and issue_alu_ready are high; select while ready is low
// has no effect and nothing is captured.
module simf_pass_seq #(
  parameter int LANES = 16,
  parameter int LAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_alu_select,
  input  logic [5:0]    issue_wfid,
  input  logic [2:0]    issue_opcode,
  input  logic [9:0]    issue_source_reg1,
  input  logic [9:0]    issue_source_reg2,
  input  logic [9:0]    issue_dest_reg1,
  input  logic [31:0]   issue_instr_pc,
  input  logic [63:0]   exec_rd_exec_value,
  input  logic [2047:0] vgpr_source1_data,
  input  logic [2047:0] vgpr_source2_data,
  output logic          issue_alu_ready,
  output logic          vgpr_source1_rd_en,
  output logic          vgpr_source2_rd_en,
  output logic [9:0]    vgpr_source1_addr,
  output logic [9:0]    vgpr_source2_addr,
  output logic          vgpr_wr_en,
  output logic [9:0]    vgpr_dest_addr,
  output logic [2047:0] vgpr_dest_data,
  output logic [63:0]   vgpr_wr_mask,
  output logic          vgpr_instr_done,
  output logic [5:0]    vgpr_instr_done_wfid,
  output logic [31:0]   tracemon_retire_pc,
  output logic [2:0]    state_dbg
);

  localparam int PASSES = 64 / LANES;
  localparam int SW     = LANES * 32;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_WB    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [5:0]    wfid_q;
  logic [2:0]    opcode_q;
  logic [9:0]    src1_q, src2_q, dst_q;
  logic [31:0]   pc_q;
  logic [63:0]   exec_q;
  logic [PW-1:0] pass_q;

  logic [2047:0] op_a, op_b, res_buf;
  logic [SW-1:0] lane_res;

  logic [SW-1:0] pipe_data [LAT];
  logic [PW-1:0] pipe_tag  [LAT];
  logic [LAT-1:0] pipe_vld;

  logic accept;
  assign accept = (state == S_IDLE) && issue_alu_select;

`ifdef SIMF_SEQ_DENORM_FLUSH_EN
  function automatic logic [31:0] flush_den(input logic [31:0] x);
    if ((x[30:23] == 8'h00) && (x[22:0] != 23'd0)) return {x[31], 31'd0};
    return x;
  endfunction
`endif

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] lane_op(input logic [2:0]  op,
                                          input logic [31:0] a_in,
                                          input logic [31:0] b_in);
    logic [31:0] a, b, ka, kb;
    a = a_in;
    b = b_in;
`ifdef SIMF_SEQ_DENORM_FLUSH_EN
    if (op[2]) begin
      a = flush_den(a);
      b = flush_den(b);
    end
`endif
    // Order key maps IEEE floats onto unsigned order, so -0 sorts below +0.
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    case (op)
      3'd0: return a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: begin
        if (is_nan(a)) return is_nan(b) ? a : b;
        if (is_nan(b)) return a;
        return (kb < ka) ? b : a;
      end
      3'd5: begin
        if (is_nan(a)) return is_nan(b) ? a : b;
        if (is_nan(b)) return a;
        return (kb > ka) ? b : a;
      end
      3'd6: return {~a[31], a[30:0]};
      default: return {1'b0, a[30:0]};
    endcase
  endfunction

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue_alu_select)
                 state_nxt = (exec_rd_exec_value == 64'd0) ? S_WB : S_READ;
      S_READ:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (pass_q == LAST_PASS) state_nxt = S_DRAIN;
      // The last pass is leaving the pipe this cycle and lands in res_buf
      // on this edge, so the buffer is complete during WB.
      S_DRAIN: if (pipe_vld[LAT-1] && (pipe_tag[LAT-1] == LAST_PASS))
                 state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Instruction capture and pass counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wfid_q   <= '0;
      opcode_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      pc_q     <= '0;
      exec_q   <= '0;
      pass_q   <= '0;
    end else begin
      if (accept) begin
        wfid_q   <= issue_wfid;
        opcode_q <= issue_opcode;
        src1_q   <= issue_source_reg1;
        src2_q   <= issue_source_reg2;
        dst_q    <= issue_dest_reg1;
        pc_q     <= issue_instr_pc;
        exec_q   <= exec_rd_exec_value;
      end
      if (state == S_RUN) begin
        if (pass_q == LAST_PASS) pass_q <= '0;
        else                     pass_q <= pass_q + 1'b1;
      end
    end
  end

  // Operand buffer: data returns the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      op_a <= vgpr_source1_data;
      op_b <= vgpr_source2_data;
    end
  end

  // All lanes of the current pass, computed regardless of exec.
  always_comb begin
    lane_res = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_res[l*32 +: 32] = lane_op(opcode_q,
                                     op_a[int'(pass_q)*SW + l*32 +: 32],
                                     op_b[int'(pass_q)*SW + l*32 +: 32]);
    end
  end

  // Lane pipe control: only valids/tags need reset so an abort drops
  // in-flight passes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= (state == S_RUN);
      pipe_tag[0] <= pass_q;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= lane_res;
    for (int i = 1; i < LAT; i++) pipe_data[i] <= pipe_data[i-1];
    if (pipe_vld[LAT-1])
      res_buf[int'(pipe_tag[LAT-1])*SW +: SW] <= pipe_data[LAT-1];
  end

  // Outputs are decodes of registered state; buses read 0 outside their
  // owning state.
  logic in_read, in_wb;
  assign in_read = (state == S_READ);
  assign in_wb   = (state == S_WB);

  assign issue_alu_ready      = (state == S_IDLE);
  assign vgpr_source1_rd_en   = in_read;
  assign vgpr_source2_rd_en   = in_read;
  assign vgpr_source1_addr    = in_read ? src1_q : 10'd0;
  assign vgpr_source2_addr    = in_read ? src2_q : 10'd0;
  assign vgpr_wr_en           = in_wb && (exec_q != 64'd0);
  assign vgpr_instr_done      = in_wb;
  assign vgpr_dest_addr       = in_wb ? dst_q : 10'd0;
  assign vgpr_dest_data       = in_wb ? res_buf : 2048'd0;
  assign vgpr_wr_mask         = in_wb ? exec_q : 64'd0;
  assign vgpr_instr_done_wfid = in_wb ? wfid_q : 6'd0;
  assign tracemon_retire_pc   = in_wb ? pc_q : 32'd0;
  assign state_dbg            = state;

endmodule

// File: tb/tb_simf_pass_seq.sv
`timescale 1ns/1ps
module tb_simf_pass_seq;

  localparam int ND = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [ND-1:0] sel;
  logic [5:0]    wfid;
  logic [2:0]    opc;
  logic [9:0]    s1, s2, dst;
  logic [31:0]   pc;
  logic [63:0]   exec;
  logic [2047:0] src1_data, src2_data;
  logic [2047:0] stim_a, stim_b;

  // ---------------- per-DUT outputs ----------------
  logic [ND-1:0]       rdy, rd1, rd2, wr, done;
  logic [ND*10-1:0]    a1_all, a2_all, da_all;
  logic [ND*2048-1:0]  dd_all;
  logic [ND*64-1:0]    wm_all;
  logic [ND*6-1:0]     dw_all;
  logic [ND*32-1:0]    rpc_all;
  logic [ND*3-1:0]     st_all;

  // Instance 0: defaults; 1: LANES=8 LAT=8; 2: LANES=64 LAT=1
  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      simf_pass_seq #(
        .LANES(g == 0 ? 16 : (g == 1 ? 8 : 64)),
        .LAT  (g == 0 ? 4  : (g == 1 ? 8 : 1))
      ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .issue_alu_select     (sel[g]),
        .issue_wfid           (wfid),
        .issue_opcode         (opc),
        .issue_source_reg1    (s1),
        .issue_source_reg2    (s2),
        .issue_dest_reg1      (dst),
        .issue_instr_pc       (pc),
        .exec_rd_exec_value   (exec),
        .vgpr_source1_data    (src1_data),
        .vgpr_source2_data    (src2_data),
        .issue_alu_ready      (rdy[g]),
        .vgpr_source1_rd_en   (rd1[g]),
        .vgpr_source2_rd_en   (rd2[g]),
        .vgpr_source1_addr    (a1_all[g*10 +: 10]),
        .vgpr_source2_addr    (a2_all[g*10 +: 10]),
        .vgpr_wr_en           (wr[g]),
        .vgpr_dest_addr       (da_all[g*10 +: 10]),
        .vgpr_dest_data       (dd_all[g*2048 +: 2048]),
        .vgpr_wr_mask         (wm_all[g*64 +: 64]),
        .vgpr_instr_done      (done[g]),
        .vgpr_instr_done_wfid (dw_all[g*6 +: 6]),
        .tracemon_retire_pc   (rpc_all[g*32 +: 32]),
        .state_dbg            (st_all[g*3 +: 3])
      );
    end
  endgenerate

  // VGPR file responder: valid data only the cycle after a read strobe,
  // complemented garbage otherwise.
  always @(posedge clk) begin
    if (|{rd1, rd2}) begin
      src1_data <= stim_a;
      src2_data <= stim_b;
    end else begin
      src1_data <= ~stim_a;
      src2_data <= ~stim_b;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2047:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_data(input int g, input logic [2047:0] exp_d);
    int idx;
    logic [2047:0] got;
    got = dd_all[g*2048 +: 2048];
    idx = 0;
    for (int t = 63; t >= 0; t--)
      if (got[t*32 +: 32] !== exp_d[t*32 +: 32]) idx = t;
    check($sformatf("data_dut%0d_t%0d", g, idx), {32'd0, got[idx*32 +: 32]},
          {32'd0, exp_d[idx*32 +: 32]});
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan_f(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Strict "x < y" on non-NaN floats by sign then magnitude.
  function automatic bit f_less(input logic [31:0] x, input logic [31:0] y);
    if (x[31] != y[31]) return x[31];
    if (!x[31]) return x[30:0] < y[30:0];
    return x[30:0] > y[30:0];
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a_in,
                                         input logic [31:0] b_in);
    logic [31:0] a, b;
    a = a_in;
    b = b_in;
`ifdef SIMF_SEQ_DENORM_FLUSH_EN
    if (op >= 3'd4) begin
      if (a[30:23] == 0 && a[22:0] != 0) a = a & 32'h8000_0000;
      if (b[30:23] == 0 && b[22:0] != 0) b = b & 32'h8000_0000;
    end
`endif
    case (op)
      3'd0: return a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd6: return a ^ 32'h8000_0000;
      3'd7: return a & 32'h7FFF_FFFF;
      default: begin
        if (is_nan_f(a) && is_nan_f(b)) return a;
        if (is_nan_f(a)) return b;
        if (is_nan_f(b)) return a;
        if (op == 3'd4) return f_less(b, a) ? b : a;
        return f_less(a, b) ? b : a;
      end
    endcase
  endfunction

  function automatic int wb_cycle(input int g);
    int lanes, lat;
    lanes = (g == 0) ? 16 : ((g == 1) ? 8 : 64);
    lat   = (g == 0) ? 4  : ((g == 1) ? 8 : 1);
    return 3 + 64 / lanes + lat;
  endfunction

  function automatic logic [2047:0] fill(input logic [31:0] v);
    return {64{v}};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000;
      3: return 32'hFF80_0001;
      4: return 32'h0000_0001;
      5: return 32'h8000_0003;
      6: return 32'h3F80_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2047:0] rand_vec();
    logic [2047:0] v;
    for (int t = 0; t < 64; t++) v[t*32 +: 32] = rand_word();
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_instr(input int g, input logic [2:0] op, input logic [2047:0] a,
                           input logic [2047:0] b, input logic [63:0] ex, input bit spam);
    logic [5:0]    w;
    logic [31:0]   p;
    logic [9:0]    r1, r2, rd;
    logic [2047:0] exp_d;
    int k, rd_cnt;
    bit seen;
    w = 6'($urandom); p = $urandom;
    r1 = 10'($urandom); r2 = 10'($urandom); rd = 10'($urandom);
    for (int t = 0; t < 64; t++) exp_d[t*32 +: 32] = ref_op(op, a[t*32 +: 32], b[t*32 +: 32]);
    exp_q.push_back(exp_d);

    k = 0;
    while (!rdy[g] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("ready_before_issue_dut%0d", g), {63'd0, rdy[g]}, 64'd1);

    stim_a = a; stim_b = b;
    wfid = w; opc = op; s1 = r1; s2 = r2; dst = rd; pc = p; exec = ex;
    sel[g] = 1'b1;
    @(negedge clk);
    k = 1; rd_cnt = 0; seen = 0;
    while (k <= 60) begin
      if (rd1[g] || rd2[g]) begin
        rd_cnt++;
        check("rd_cycle", k, 1);
        check("rd_pair", {62'd0, rd1[g], rd2[g]}, 64'd3);
        check("rd_addr1", {54'd0, a1_all[g*10 +: 10]}, {54'd0, r1});
        check("rd_addr2", {54'd0, a2_all[g*10 +: 10]}, {54'd0, r2});
      end
      if (done[g]) begin
        sel[g] = 1'b0;
        seen = 1;
        break;
      end
      if (spam) begin
        sel[g] = 1'b1;
        wfid = 6'($urandom); opc = 3'($urandom); s1 = 10'($urandom); s2 = 10'($urandom);
        dst = 10'($urandom); pc = $urandom; exec = {$urandom, $urandom};
      end else begin
        sel[g] = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    sel[g] = 1'b0;
    exp_d = exp_q.pop_front();
    check($sformatf("done_seen_dut%0d", g), {63'd0, seen}, 64'd1);
    if (seen) begin
      check($sformatf("wb_cycle_dut%0d", g), k, (ex == 0) ? 1 : wb_cycle(g));
      check("wr_en", {63'd0, wr[g]}, {63'd0, (ex != 0)});
      check("rd_count", rd_cnt, (ex == 0) ? 0 : 1);
      check("wr_mask", wm_all[g*64 +: 64], ex);
      check("done_wfid", {58'd0, dw_all[g*6 +: 6]}, {58'd0, w});
      check("retire_pc", {32'd0, rpc_all[g*32 +: 32]}, {32'd0, p});
      check("dest_addr", {54'd0, da_all[g*10 +: 10]}, {54'd0, rd});
      if (ex != 0) check_data(g, exp_d);
    end
    @(negedge clk);
    check("post_done_wr", {62'd0, done[g], wr[g]}, 64'd0);
    check("post_ready", {63'd0, rdy[g]}, 64'd1);
    check("post_bus_zero", {59'd0, |dd_all[g*2048 +: 2048], |wm_all[g*64 +: 64],
          |dw_all[g*6 +: 6], |rpc_all[g*32 +: 32], |da_all[g*10 +: 10]}, 64'd0);
  endtask

  // Issue on the default instance, then pull reset in cycle T+6.
  task automatic run_abort();
    int k, bad;
    stim_a = rand_vec(); stim_b = rand_vec();
    wfid = 6'd9; opc = 3'd2; s1 = 10'd1; s2 = 10'd2; dst = 10'd3; pc = 32'h1234; exec = '1;
    sel[0] = 1'b1;
    @(negedge clk);
    sel[0] = 1'b0;
    k = 1; bad = 0;
    while (k < 6) begin
      if (done[0] || wr[0]) bad++;
      @(negedge clk);
      k++;
    end
    rst = 1'b0;
    #1;
    check("abort_ready_in_reset", {63'd0, rdy[0]}, 64'd1);
    repeat (2) begin
      @(negedge clk);
      if (done[0] || wr[0]) bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_after", {63'd0, rdy[0]}, 64'd1);
    repeat (20) begin
      if (done[0] || wr[0]) bad++;
      @(negedge clk);
    end
    check("abort_no_wb", bad, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2047:0] va, vb;
    rst = 1'b0; sel = '0;
    wfid = '0; opc = '0; s1 = '0; s2 = '0; dst = '0; pc = '0; exec = '0;
    stim_a = '0; stim_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {61'd0, rdy}, 64'd7);
    check("rst_strobes", {52'd0, rd1, rd2, wr, done}, 64'd0);
    check("rst_addr", {61'd0, |a1_all, |a2_all, |da_all}, 64'd0);
    check("rst_data_mask", {62'd0, |dd_all, |wm_all}, 64'd0);
    check("rst_wfid_pc", {62'd0, |dw_all, |rpc_all}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 64; t++) va[t*32 +: 32] = t;
    run_instr(0, 3'd0, va, rand_vec(), '1, 0);
    run_instr(0, 3'd4, fill(32'h3F80_0000), fill(32'hBF80_0000), '1, 0);
    run_instr(0, 3'd5, fill(32'h8000_0000), fill(32'h0000_0000), '1, 0);
    run_instr(0, 3'd4, fill(32'h7FC0_0000), fill(32'h4000_0000), '1, 0);
    run_instr(0, 3'd0, rand_vec(), rand_vec(), 64'd0, 0);
    run_instr(0, 3'd1, rand_vec(), rand_vec(), 64'h0000_0000_0000_FFFF, 1);
    run_abort();
    run_instr(0, 3'd3, rand_vec(), rand_vec(), {$urandom, $urandom}, 0);
    run_instr(0, 3'd6, fill(32'h0000_0001), rand_vec(), '1, 0);

    for (int g = 1; g < ND; g++) begin
      for (int t = 0; t < 64; t++) vb[t*32 +: 32] = 32'hA500_0000 + t;
      run_instr(g, 3'd0, vb, rand_vec(), '1, 0);
      run_instr(g, 3'd5, rand_vec(), rand_vec(), {$urandom, $urandom}, 0);
      run_instr(g, 3'd0, rand_vec(), rand_vec(), 64'd0, 0);
    end

    for (int i = 0; i < 24; i++) begin
      int g;
      logic [63:0] ex;
      g = $urandom_range(0, ND - 1);
      ex = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      run_instr(g, 3'($urandom_range(0, 7)), rand_vec(), rand_vec(), ex, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simf_pass_seq.md
# simf_pass_seq

Parametrised multi-pass SIMF execution sequencer. It accepts one vector instruction at a time from issue and reads two VGPR operands for a 64-thread wavefront. The operands are processed LANES threads per cycle through an internal LAT-deep lane pipeline, and the results are written back as one masked VGPR write with instruction-done and retire reporting. It sits between issue, the VGPR file and the tracemon, and generalises the fixed SIMF ALU wrapper in lane count, latency and exec-mask handling.

## Interface
Parameters:
- LANES, 16, threads per pass; legal values 8, 16, 32, 64; PASSES = 64/LANES.
- LAT, 4, lane pipeline depth in register stages; legal range 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- issue_alu_select  in  1  instruction offered; accepted only when issue_alu_ready=1.
- issue_wfid  in  6  wavefront id.
- issue_opcode  in  3  0 MOV, 1 AND, 2 OR, 3 XOR, 4 MIN_F32, 5 MAX_F32, 6 NEG_F32, 7 ABS_F32.
- issue_source_reg1, issue_source_reg2  in  10  VGPR operand addresses A and B.
- issue_dest_reg1  in  10  VGPR destination address.
- issue_instr_pc  in  32  instruction PC.
- exec_rd_exec_value  in  64  exec mask, sampled at accept.
- vgpr_source1_data, vgpr_source2_data  in  2048  operand data; thread t occupies bits [32t+31:32t].
- issue_alu_ready  out  1  high only in IDLE.
- vgpr_source1_rd_en, vgpr_source2_rd_en  out  1  operand read strobes.
- vgpr_source1_addr, vgpr_source2_addr  out  10  read addresses.
- vgpr_wr_en  out  1  writeback strobe.
- vgpr_dest_addr  out  10  write address.
- vgpr_dest_data  out  2048  write data.
- vgpr_wr_mask  out  64  write mask; equals the latched exec mask.
- vgpr_instr_done  out  1  one-cycle completion pulse.
- vgpr_instr_done_wfid  out  6  wfid of the completed instruction.
- tracemon_retire_pc  out  32  PC of the completed instruction; valid with vgpr_instr_done.

## Operation
States:
- IDLE: ready=1.
- READ: rd_en=1 for both operands; addresses equal the latched sources.
- LOAD: vgpr_source*_data sampled into the 4096-bit operand buffer.
- RUN: one pass issued per cycle; pass counter p runs 0..PASSES-1.
- DRAIN: waits for the pipeline to empty.
- WB: vgpr_wr_en=1, vgpr_instr_done=1.

Transitions:
- Accept (IDLE and select=1) latches wfid, opcode, sources, destination, PC and exec.
- If the latched exec is zero: IDLE goes directly to WB with vgpr_wr_en=0 and vgpr_instr_done=1.
- If exec is nonzero: IDLE→READ→LOAD→RUN.
- RUN→DRAIN after p=PASSES-1. p wraps to 0 on that transition.
- DRAIN→WB when the last pass reaches the buffer.
- WB→IDLE.

Pass datapath:
- Pass p handles threads p·LANES..p·LANES+LANES-1.
- Per-lane results enter a LAT-stage shift pipe tagged with p and a valid bit.
- On exit, results are written into the 2048-bit result buffer at slice p.

Per-lane operations on 32-bit values:
- MOV returns A; AND, OR and XOR are bitwise on A and B.
- NEG flips bit 31 of A; ABS clears bit 31 of A.
- MIN and MAX compare by the order key: key = sign ? ~x : x|0x80000000, compared unsigned. Consequently -0 < +0.
- NaN (exponent 0xFF, nonzero mantissa): if exactly one operand is NaN, the result is the other operand. If both are NaN, the result is A.
- On equal keys, the result is A.

Lanes are computed regardless of exec. Masking is applied only through vgpr_wr_mask.

Other rules:
- select while ready=0 is ignored; nothing is latched.
- Reset mid-instruction: all state returns to IDLE and the pipe valids clear. No writeback and no done pulse occur.
- Reset values: issue_alu_ready=1; every other output is 0, including all data and address buses.

## Timing
- Accept occurs in cycle T.
- READ occurs in T+1. LOAD occurs in T+2.
- Passes issue in T+3..T+2+PASSES.
- The last result is written to the buffer at the end of T+2+PASSES+LAT.
- WB occurs in T+3+PASSES+LAT; issue_alu_ready=1 again in T+4+PASSES+LAT.
- Defaults (LANES=16, LAT=4): WB in T+11, next accept in T+12.
- With LANES=64 and LAT=1: WB in T+5.
- With zero exec: WB in T+1, ready in T+2.
- Outputs are registered. vgpr_dest_data, vgpr_dest_addr, vgpr_wr_mask, done_wfid and retire_pc hold their values during WB only and are 0 otherwise.

## Configuration
- SIMF_SEQ_DENORM_FLUSH_EN defined: for MIN, MAX, NEG and ABS, any operand with exponent 0 and nonzero mantissa is replaced by a zero of the same sign before the operation.
- SIMF_SEQ_DENORM_FLUSH_EN undefined: denormals pass through unchanged.
- MOV, AND, OR and XOR are never flushed.

## Test plan
- Reset held low, then released: ready=1 and all other outputs 0. Then, at defaults, MOV with A thread t = t and exec all-ones -> WB at T+11, data thread t = t, mask 0xFFFF_FFFF_FFFF_FFFF, done_wfid and retire_pc match the issued values.
- MIN_F32 with A=0x3F800000 (1.0) and B=0xBF800000 (-1.0) -> 0xBF800000. MAX of 0x80000000 (-0) and 0x00000000 (+0) -> 0x00000000. MIN of 0x7FC00000 (NaN) and 0x40000000 (2.0) -> 0x40000000.
- exec=0 -> no rd_en pulses, done pulses in T+1 with vgpr_wr_en=0, and a new accept is taken in T+2.
- Second select asserted in T+1..T+11 -> ignored. Exec 0x00000000_0000FFFF -> vgpr_wr_mask equals the exec value exactly.
- Reset asserted in T+6 -> no vgpr_wr_en and no done; ready=1 after release. The next instruction completes with correct data.
- Denormal handling: NEG of A=0x00000001 -> 0x80000000 when SIMF_SEQ_DENORM_FLUSH_EN is defined, 0x80000001 when it is not. Sweep LANES 8/64 and LAT 1/8 and check the WB cycle equals T+3+PASSES+LAT.
